// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants and block/word types.
package md5_pkg;
  localparam int MD5_BLOCK_WORDS = 16;
  localparam int MD5_LEN_WORD = 14;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  typedef logic [31:0] md5_word_t;
  typedef md5_word_t [MD5_BLOCK_WORDS-1:0] md5_block_t;
  localparam md5_word_t MD5_INIT_A = 32'h67452301;
  localparam md5_word_t MD5_INIT_B = 32'hefcdab89;
  localparam md5_word_t MD5_INIT_C = 32'h98badcfe;
  localparam md5_word_t MD5_INIT_D = 32'h10325476;
endpackage

// File: rtl/md5_block_formatter_if.sv
// md5_block_formatter_if: guess-in / block-out valid-ready handshake bundle.
interface md5_block_formatter_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
);
  import md5_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [8*MAX_LEN-1:0] in_guess;
  logic [LEN_W-1:0] in_len;
  logic out_valid;
  logic out_ready;
  md5_block_t out_block;
  modport master(output in_valid, in_guess, in_len, out_ready, input in_ready, out_valid, out_block);
  modport slave(input in_valid, in_guess, in_len, out_ready, output in_ready, out_valid, out_block);
endinterface

// File: rtl/md5_block_formatter_pad_word.sv
// md5_pad_word: one padded message word (data below len, 0x80 at len, zero above).
module md5_pad_word
  import md5_pkg::*;
(
  input  logic [3:0]      i_idx,
  input  logic [3:0][7:0] i_bytes,
  input  logic [5:0]      i_len,
  output md5_word_t       o_word
);
  for (genvar b = 0; b < 4; b++) begin : g_lane
    logic [5:0] w_pos;
    assign w_pos = {i_idx, 2'(b)};
    assign o_word[8*b +: 8] = w_pos < i_len ? i_bytes[b] : w_pos == i_len ? MD5_PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/md5_block_formatter.sv
// md5_block_formatter: two-stage back-pressurable MD5 single-block padder.
// MD5_FMT_LEN_CHECK_EN: drop oversize guesses and report them instead of clamping.
module md5_block_formatter
  import md5_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic        clk,
  input  logic        reset,
  md5_block_formatter_if.slave bus,
  output logic        len_err,
  output logic [15:0] err_count
);
  logic w_s1_adv, w_s2_adv, w_acc, w_over, w_load;
  logic [LEN_W-1:0] w_len;
  logic r_s1_valid, r_s2_valid;
  logic [8*MAX_LEN-1:0] r_s1_guess;
  logic [LEN_W-1:0] r_s1_len;
  md5_block_t r_s2_block, w_block;
  logic [3:0][7:0] w_bytes [MD5_LEN_WORD];
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv && !reset;
  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_over = bus.in_len > LEN_W'(MAX_LEN);
`ifdef MD5_FMT_LEN_CHECK_EN
  logic r_len_err;
  logic [15:0] r_err_count;
  assign w_load = w_acc && !w_over;
  assign w_len = bus.in_len;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len_err <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_len_err <= w_acc && w_over;
      if (w_acc && w_over && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
    end
  end
  assign len_err = r_len_err;
  assign err_count = r_err_count;
`else
  assign w_load = w_acc;
  assign w_len = w_over ? LEN_W'(MAX_LEN) : bus.in_len;
  assign len_err = 1'b0;
  assign err_count = '0;
`endif
  // Input bytes beyond MAX_LEN do not exist; those lanes only ever see padding.
  for (genvar g = 0; g < MD5_LEN_WORD; g++) begin : g_word
    for (genvar h = 0; h < 4; h++) begin : g_byte
      if (4*g + h < MAX_LEN) begin : g_data
        assign w_bytes[g][h] = r_s1_guess[8*(MAX_LEN-4*g-h)-1 -: 8];
      end else begin : g_zero
        assign w_bytes[g][h] = 8'h00;
      end
    end
    md5_pad_word u_pad (
      .i_idx  (4'(g)),
      .i_bytes(w_bytes[g]),
      .i_len  (6'(r_s1_len)),
      .o_word (w_block[g])
    );
  end
  assign w_block[MD5_LEN_WORD] = 32'(r_s1_len) << 3;
  assign w_block[MD5_BLOCK_WORDS-1] = '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_guess <= '0;
      r_s1_len <= '0;
      r_s2_valid <= 1'b0;
      r_s2_block <= '0;
    end else begin
      if (w_s1_adv) r_s1_valid <= w_load;
      if (w_s1_adv && w_load) begin
        r_s1_guess <= bus.in_guess;
        r_s1_len <= w_len;
      end
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) r_s2_block <= w_block;
    end
  end
  assign bus.out_valid = r_s2_valid;
  assign bus.out_block = r_s2_block;
endmodule

// File: tb/tb_md5_block_formatter.sv
// tb_md5_block_formatter: directed checks of padding, latency, stall, reset and oversize handling.
module tb_md5_block_formatter;
  import md5_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic len_err;
  logic [15:0] err_count;
  int checks = 0;
  int errors = 0;
  md5_block_formatter_if #(.MAX_LEN(16)) bus ();
  md5_block_formatter #(.MAX_LEN(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .len_err  (len_err),
    .err_count(err_count)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic md5_block_t fmt(input logic [127:0] g, input int len);
    md5_block_t b = '0;
    for (int i = 0; i < len; i++) b[i/4][8*(i%4) +: 8] = g[127-8*i -: 8];
    b[len/4][8*(len%4) +: 8] = 8'h80;
    b[14] = 32'(len * 8);
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [127:0] g, input logic [4:0] len, input md5_block_t e);
    bus.in_guess = g;
    bus.in_len = len;
    bus.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 512'(bus.in_ready), 512'(1));
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 512'(bus.out_valid), 512'(0));
    tick();
    chk({tag, "_lat2"}, 512'(bus.out_valid), 512'(1));
    chk({tag, "_block"}, bus.out_block, e);
    tick();
    chk({tag, "_drain"}, 512'(bus.out_valid), 512'(0));
  endtask

  initial begin
    md5_block_t e, held;
    logic [127:0] gs [8];
    int sent, rcv, last_emit, emits_late;
    logic acc, emit;
    bus.in_valid = 1'b0;
    bus.in_guess = '0;
    bus.in_len = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 512'(bus.in_ready), 512'(0));
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_out_block", bus.out_block, 512'(0));
    chk("rst_len_err", 512'(len_err), 512'(0));
    chk("rst_err_count", 512'(err_count), 512'(0));
    reset = 1'b0;
    tick();
    e = '0;
    e[0] = 32'h00000080;
    run_one("len0", 128'h0, 5'd0, e);
    e = '0;
    e[0] = 32'h80636261;
    e[14] = 32'h00000018;
    run_one("abc", {"abc", {13{8'hFF}}}, 5'd3, e);
    e = '0;
    e[0] = 32'h33323130;
    e[1] = 32'h37363534;
    e[2] = 32'h62613938;
    e[3] = 32'h66656463;
    e[4] = 32'h00000080;
    e[14] = 32'h00000080;
    run_one("len16", "0123456789abcdef", 5'd16, e);
    for (int i = 0; i < 8; i++) gs[i] = {8'(8'h30 + i), {15{8'(8'hA0 + i)}}};
    sent = 0;
    rcv = 0;
    last_emit = -1;
    emits_late = 0;
    held = '0;
    for (int c = 0; c < 40 && !(sent == 8 && rcv == 8); c++) begin
      bus.in_valid = sent < 8;
      bus.in_guess = sent < 8 ? gs[sent] : '0;
      bus.in_len = 5'(sent + 1);
      bus.out_ready = !(c >= 3 && c <= 7);
      #1;
      acc = bus.in_valid && bus.in_ready;
      emit = bus.out_valid && bus.out_ready;
      if (c >= 3 && c <= 7) chk($sformatf("stall_in_ready_c%0d", c), 512'(bus.in_ready), 512'(0));
      if (c == 3) held = bus.out_block;
      if (c >= 4 && c <= 7) chk($sformatf("stall_hold_c%0d", c), bus.out_block, held);
      if (emit) begin
        chk($sformatf("stream_blk%0d", rcv), bus.out_block, fmt(gs[rcv], rcv + 1));
        last_emit = c;
        if (c >= 8) emits_late++;
      end
      tick();
      sent += int'(acc);
      rcv += int'(emit);
    end
    chk("stream_count", 512'(rcv), 512'(8));
    chk("stream_last_cycle", 512'(last_emit), 512'(14));
    chk("stream_sustained", 512'(emits_late), 512'(7));
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_len = 5'd1;
    bus.in_guess = {8'h41, {15{8'h00}}};
    bus.in_valid = 1'b1;
    tick();
    bus.in_guess = {8'h42, {15{8'h00}}};
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 512'(bus.out_valid), 512'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    chk("midrst_valid", 512'(bus.out_valid), 512'(0));
    chk("midrst_block", bus.out_block, 512'(0));
    tick();
    chk("midrst_stale1", 512'(bus.out_valid), 512'(0));
    tick();
    chk("midrst_stale2", 512'(bus.out_valid), 512'(0));
    e = '0;
    e[0] = 32'h00807978;
    e[14] = 32'h00000010;
    run_one("post_rst", {"xy", {14{8'h00}}}, 5'd2, e);
`ifdef MD5_FMT_LEN_CHECK_EN
    bus.in_guess = "0123456789abcdef";
    bus.in_len = 5'd17;
    bus.in_valid = 1'b1;
    #1;
    chk("over_in_ready", 512'(bus.in_ready), 512'(1));
    tick();
    bus.in_valid = 1'b0;
    chk("over_len_err", 512'(len_err), 512'(1));
    chk("over_err_count", 512'(err_count), 512'(1));
    chk("over_no_s2", 512'(bus.out_valid), 512'(0));
    tick();
    chk("over_len_err_pulse", 512'(len_err), 512'(0));
    chk("over_no_block", 512'(bus.out_valid), 512'(0));
    tick();
    chk("over_no_block2", 512'(bus.out_valid), 512'(0));
    chk("over_err_count_hold", 512'(err_count), 512'(1));
`else
    e = '0;
    e[0] = 32'h33323130;
    e[1] = 32'h37363534;
    e[2] = 32'h62613938;
    e[3] = 32'h66656463;
    e[4] = 32'h00000080;
    e[14] = 32'h00000080;
    run_one("over_clamp", "0123456789abcdef", 5'd17, e);
    chk("over_len_err_tied", 512'(len_err), 512'(0));
    chk("over_err_count_tied", 512'(err_count), 512'(0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
